// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the program counter, drives the instruction memory and
// registers the fetched word into IF/ID, with stall/flush/redirect handling.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic [31:0]      instr_code,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             fault,
    output logic [31:0]      fault_pc,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0] MemLimit = 32'(MEM_BYTES);
    localparam logic [31:0] LastWord = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        redirect;
    logic [31:0] target;
    logic        target_ok;
    logic [31:0] pc_plus4;
    logic [31:0] pc_seq;

    assign redirect  = jump | branch_taken;
    assign target    = jump ? jump_target : branch_target;
    assign target_ok = (target[1:0] == 2'b00) && (target <= LastWord);
    assign pc_plus4  = pc_q + 32'd4;
    assign pc_seq    = (pc_plus4 >= MemLimit) ? 32'd0 : pc_plus4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        cnt_d      = cnt_q;

        unique case (state_q)
            StBoot: begin
                // One settle cycle for the memory image; controls ignored.
                state_d = StRun;
            end
            StRun: begin
                if (redirect) begin
                    // Wrong-path word is discarded on any redirect.
                    instr_d = 32'd0;
                    pc4_d   = 32'd0;
                    valid_d = 1'b0;
                    if (target_ok) begin
                        pc_d = target;
                    end else begin
                        state_d    = StFault;
                        fault_d    = 1'b1;
                        fault_pc_d = target;
                    end
                end else if (stall) begin
                    if (flush) begin
                        instr_d = 32'd0;
                        pc4_d   = 32'd0;
                        valid_d = 1'b0;
                    end
                end else begin
                    pc_d = pc_seq;
                    if (flush) begin
                        instr_d = 32'd0;
                        pc4_d   = 32'd0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = instr_code;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            StFault: begin
                // Parked until reset.
            end
            default: state_d = StFault;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a behavioural
// fetch model driven by the same 16-word memory image.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target, instr_code;
    logic [31:0] pc, if_id_instr, if_id_pc4, fault_pc;
    logic        if_id_valid, fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [16];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state; mode 0 = boot, 1 = run, 2 = fault.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4, m_fault_pc;
    logic        m_valid, m_fault;
    logic [15:0] m_cnt;
    logic [31:0] saved_pc;

    always #5 clk = ~clk;

    assign instr_code = (pc < 32'd64) ? mem[pc[5:2]] : 32'h0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_BYTES(64),
        .CNT_W    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .instr_code   (instr_code),
        .pc           (pc),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fault        (fault),
        .fault_pc     (fault_pc),
        .fetch_count  (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        m_instr = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
    endtask

    // One clock edge of the fetch rules applied to the model.
    task automatic model_edge();
        logic [31:0] tgt;
        logic [31:0] nxt;
        if (reset) begin
            m_mode = 0; m_pc = 32'd0; bubble();
            m_fault = 1'b0; m_fault_pc = 32'd0; m_cnt = 16'd0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (jump || branch_taken) begin
                tgt = jump ? jump_target : branch_target;
                bubble();
                if (tgt % 4 == 0 && tgt <= 60) begin
                    m_pc = tgt;
                end else begin
                    m_mode = 2; m_fault = 1'b1; m_fault_pc = tgt;
                end
            end else if (stall) begin
                if (flush) bubble();
            end else begin
                nxt = m_pc + 32'd4;
                if (flush) begin
                    bubble();
                end else begin
                    m_instr = mem[m_pc / 4];
                    m_pc4   = nxt;
                    m_valid = 1'b1;
                    m_cnt   = m_cnt + 16'd1;
                end
                m_pc = (nxt >= 64) ? 32'd0 : nxt;
            end
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("fault_pc", fault_pc, m_fault_pc);
        chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_ctl(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                           input logic jp, input logic [31:0] jt);
        stall = st; flush = fl; branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h8c2b_000c;
        mem[2] = 32'h682b_1037;
        mem[8] = 32'h38ef_0043;
        m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_fault = 0; m_fault_pc = 0; m_cnt = 0;

        reset = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        step();
        chk("reset_pc", pc, 32'd0);
        chk("reset_valid", {31'd0, if_id_valid}, 32'd0);

        reset = 1'b0;
        step();
        chk("boot_pc", pc, 32'd0);
        chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("first_instr", if_id_instr, 32'h0);
        chk("first_pc4", if_id_pc4, 32'd4);
        chk("first_valid", {31'd0, if_id_valid}, 32'd1);
        chk("first_pc", pc, 32'd4);
        step();
        chk("second_instr", if_id_instr, 32'h8c2b_000c);
        chk("second_pc4", if_id_pc4, 32'd8);
        chk("second_cnt", {16'd0, fetch_count}, 32'd2);

        stall = 1'b1;
        repeat (3) step();
        chk("stall_pc", pc, 32'd8);
        chk("stall_instr", if_id_instr, 32'h8c2b_000c);
        chk("stall_cnt", {16'd0, fetch_count}, 32'd2);
        stall = 1'b0;
        step();
        chk("release_instr", if_id_instr, 32'h682b_1037);

        set_ctl(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h20);
        step();
        chk("redir_pc", pc, 32'h20);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        chk("redir_instr", if_id_instr, 32'h38ef_0043);
        chk("redir_pc4", if_id_pc4, 32'h24);

        repeat (6) step();
        chk("pre_wrap_pc", pc, 32'h3c);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h40);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom % 40 == 0);
            set_ctl(($urandom % 4 == 0), ($urandom % 7 == 0),
                    ($urandom % 12 == 0),
                    ($urandom % 8 == 0) ? 32'($urandom_range(0, 127))
                                        : {26'd0, 4'($urandom_range(0, 15)), 2'b00},
                    ($urandom % 18 == 0),
                    ($urandom % 8 == 0) ? 32'($urandom_range(0, 127))
                                        : {26'd0, 4'($urandom_range(0, 15)), 2'b00});
            step();
        end

        reset = 1'b1;
        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        reset = 1'b0;
        step();
        step();

        saved_pc = m_pc;
        set_ctl(1'b0, 1'b0, 1'b1, 32'h12, 1'b0, 32'd0);
        step();
        chk("ill_fault", {31'd0, fault}, 32'd1);
        chk("ill_fault_pc", fault_pc, 32'h12);
        chk("ill_valid", {31'd0, if_id_valid}, 32'd0);
        chk("ill_pc", pc, saved_pc);
        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8);
        repeat (3) step();
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        chk("fault_pc_frozen", pc, saved_pc);
        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        reset = 1'b1;
        step();
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        reset = 1'b0;
        step();
        step();

        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h18);
        step();
        chk("jump18_pc", pc, 32'h18);
        set_ctl(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        reset = 1'b1;
        step();
        chk("rp_pc", pc, 32'd0);
        chk("rp_instr", if_id_instr, 32'd0);
        chk("rp_pc4", if_id_pc4, 32'd0);
        chk("rp_cnt", {16'd0, fetch_count}, 32'd0);
        reset = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h20);
        step();
        chk("rp_boot_ignores_jump", pc, 32'd0);
        set_ctl(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step();
        chk("rp_run_pc", pc, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Program-counter and fetch stage that drives the instruction memory's `pc` input.
- Captures the returned 32-bit `instr_code` into the IF/ID pipeline register.
- Handles stall, flush, and jump/branch redirects from later stages.
- Detects illegal fetch targets and parks in a fault state until reset.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, 64, instruction memory size in bytes; sequential fetch wraps at this bound.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and the IF/ID register.
- flush  input  1  load a bubble into IF/ID this cycle.
- branch_taken  input  1  redirect to branch_target.
- branch_target  input  32  branch destination byte address.
- jump  input  1  redirect to jump_target.
- jump_target  input  32  jump destination byte address.
- instr_code  input  32  big-endian word read combinationally from the instruction memory at `pc`.
- pc  output  32  current fetch address, connected to the instruction memory.
- if_id_instr  output  32  registered instruction.
- if_id_pc4  output  32  registered fetch address + 4.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fault  output  1  illegal redirect target seen; sticky.
- fault_pc  output  32  offending target address.
- fetch_count  output  CNT_W  number of valid instructions loaded into IF/ID; wraps at 2^CNT_W.

Behaviour:
- Reset:
  - Clock: single clock `clk`.
  - Reset: `reset` is synchronous and active-high.
  - While reset is sampled high at a rising edge:
    - pc = RESET_PC
    - if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0
    - fault = 0, fault_pc = 0, fetch_count = 0
    - state = BOOT
  - Reset overrides every other input, including in FAULT and mid-stall.
- State machine (states BOOT, RUN, FAULT):
  - BOOT:
    - Lasts exactly one cycle after reset deasserts, giving the memory contents one settle cycle.
    - pc holds, IF/ID holds its bubble, and all control inputs are ignored.
    - Next state: RUN.
  - RUN, priority at each edge: jump > branch_taken > stall > sequential. flush acts independently on IF/ID.
  - Redirect (jump, or branch_taken without jump):
    - Target is legal only if target[1:0] == 0 and target <= MEM_BYTES-4.
    - Legal target:
      - pc <= target.
      - IF/ID <= bubble (instr 0, pc4 0, valid 0). The wrong-path word is discarded.
      - A redirect overrides stall.
    - Illegal target:
      - Go to FAULT, with fault <= 1 and fault_pc <= target.
      - pc holds and IF/ID <= bubble.
  - stall (no redirect):
    - pc, IF/ID and fetch_count hold.
    - If flush is also high, IF/ID <= bubble while pc still holds.
  - Sequential:
    - if_id_instr <= instr_code.
    - if_id_pc4 <= pc + 4.
    - if_id_valid <= 1.
    - fetch_count increments.
    - pc <= (pc + 4 >= MEM_BYTES) ? 0 : pc + 4.
    - If flush is high, IF/ID <= bubble instead (pc still advances, no count increment).
  - FAULT:
    - pc holds, IF/ID stays bubble, fault stays 1.
    - All inputs except reset are ignored; only reset exits.
- Timing:
  - Latency: the instruction at address A appears in IF/ID on the edge after pc == A, provided there is no stall, flush or redirect.
  - The IF/ID outputs are registers only.
  - pc feeds the memory combinationally, with no added latency.
- Arithmetic:
  - pc + 4 is computed at 32-bit width.
  - fetch_count wraps modulo 2^CNT_W.

Test Plan:
- Reset and start-up:
  - Stimulus: reset high for 2 edges, then low; memory loaded with the reset-high program image.
  - Required response: BOOT cycle with pc = 0 and valid = 0.
  - Next edge: if_id_instr = 0x00000000, pc4 = 4, valid = 1, pc = 4.
  - Next edge: if_id_instr = 0x8c2b000c, pc4 = 8, fetch_count = 2.
- Stall:
  - Stimulus: stall high for 3 cycles with pc = 8.
  - Required response: pc stays 8, if_id_instr stays 0x8c2b000c, fetch_count unchanged.
  - On release: if_id_instr = 0x682b1037.
- Simultaneous redirects:
  - Stimulus: jump = 1 with jump_target = 0x20, and branch_taken = 1 with branch_target = 0x10, same cycle.
  - Required response: pc = 0x20 and valid = 0.
  - Next edge: if_id_instr = 0x38ef0043, pc4 = 0x24.
- Wrap-around:
  - Stimulus: sequential fetch reaching pc = 0x3C with no stall.
  - Required response: next pc = 0x00, if_id_pc4 = 0x40.
- Illegal target:
  - Stimulus: branch_taken with branch_target = 0x12.
  - Required response: fault = 1, fault_pc = 0x12, valid = 0, pc frozen.
  - Later jumps are ignored; reset clears fault.
- Reset precedence:
  - Stimulus: reset asserted while stall and flush are both high at pc = 0x18.
  - Required response: next edge pc = 0, all IF/ID fields 0, fetch_count = 0, state BOOT.
